// File: rtl/qspi_flash_responder_if.sv
// QSPI pin bundle between the XIP controller (master) and the flash responder (slave).
interface qspi_flash_responder_if;
  logic       sck;
  logic       ce_n;
  logic [3:0] din;
  logic [3:0] dout;
  logic       douten;

  modport master (output sck, ce_n, din, input dout, douten);
  modport slave  (input sck, ce_n, din, output dout, douten);
endinterface

// File: rtl/qspi_flash_responder.sv
// Quad I/O fast read (0xEB) flash responder with continuous-read mode over an internal byte memory.
// Optional QSPI_RESP_STATS_EN adds rd_count and sticky cmd_err outputs.
module qspi_flash_responder #(
  parameter int unsigned MEM_AW = 12,
  parameter int unsigned DUMMY  = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  qspi_flash_responder_if.slave qspi,
  input  logic                  mem_we,
  input  logic [MEM_AW-1:0]     mem_waddr,
  input  logic [7:0]            mem_wdata
`ifdef QSPI_RESP_STATS_EN
  ,
  output logic [15:0]           rd_count,
  output logic                  cmd_err
`endif
);

  typedef enum logic [2:0] {
    StIdle, StCmd, StAddr, StMode, StDummy, StData, StIgnore
  } state_e;

  localparam logic [7:0]        CmdQuadRead = 8'hEB;
  localparam logic [7:0]        PcFirstData = 8'(15 + DUMMY);
  localparam logic [MEM_AW-1:0] AddrOne     = MEM_AW'(1);

  logic [7:0] mem [2**MEM_AW];

  state_e            state_q, state_d, cur_st;
  logic [7:0]        pc_q, pc_d;
  logic [6:0]        cmd_q, cmd_d;
  // Only the low MEM_AW address bits matter since the flash address wraps on the memory size.
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [MEM_AW-1:0] rd_addr_q, rd_addr_d;
  logic              xip_q, xip_d;
  logic              nib_lo_q, nib_lo_d;
  logic [3:0]        dout_q, dout_d;
  logic              douten_q, douten_d;
  logic              first_load;
  logic [7:0]        first_byte, data_byte;

  assign first_byte  = mem[addr_q];
  assign data_byte   = mem[rd_addr_q];
  assign qspi.dout   = dout_q;
  assign qspi.douten = douten_q;

  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    xip_d      = xip_q;
    rd_addr_d  = rd_addr_q;
    nib_lo_d   = nib_lo_q;
    dout_d     = dout_q;
    douten_d   = douten_q;
    first_load = 1'b0;
    // A shift event can land on the same edge that leaves IDLE.
    cur_st     = (state_q == StIdle) ? (xip_q ? StAddr : StCmd) : state_q;

    if (qspi.ce_n) begin
      state_d  = StIdle;
      douten_d = 1'b0;
      dout_d   = 4'h0;
      pc_d     = xip_q ? 8'd8 : 8'd0;
    end else begin
      state_d = cur_st;
      if (qspi.sck) begin
        pc_d = pc_q + 8'd1;
        unique case (cur_st)
          StCmd: begin
            cmd_d = {cmd_q[5:0], qspi.din[0]};
            if (pc_q == 8'd7) begin
              state_d = ({cmd_q, qspi.din[0]} == CmdQuadRead) ? StAddr : StIgnore;
            end
          end
          StAddr: begin
            addr_d = {addr_q[MEM_AW-5:0], qspi.din};
            if (pc_q == 8'd13) state_d = StMode;
          end
          StMode: begin
            if (pc_q == 8'd14) xip_d = (qspi.din == 4'hA);
            else if (DUMMY == 0) first_load = 1'b1;
            else state_d = StDummy;
          end
          StDummy: begin
            if (pc_q == PcFirstData) first_load = 1'b1;
          end
          StData: begin
            if (nib_lo_q) begin
              dout_d    = data_byte[3:0];
              nib_lo_d  = 1'b0;
              rd_addr_d = rd_addr_q + AddrOne;
            end else begin
              dout_d   = data_byte[7:4];
              nib_lo_d = 1'b1;
            end
          end
          default: ;
        endcase

        if (first_load) begin
          state_d   = StData;
          dout_d    = first_byte[7:4];
          douten_d  = 1'b1;
          rd_addr_d = addr_q;
          nib_lo_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= StIdle;
      pc_q      <= 8'd0;
      cmd_q     <= 7'd0;
      addr_q    <= '0;
      rd_addr_q <= '0;
      xip_q     <= 1'b0;
      nib_lo_q  <= 1'b0;
      dout_q    <= 4'h0;
      douten_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      xip_q     <= xip_d;
      nib_lo_q  <= nib_lo_d;
      dout_q    <= dout_d;
      douten_q  <= douten_d;
    end
  end

`ifdef QSPI_RESP_STATS_EN
  logic [15:0] rd_count_q;
  logic        cmd_err_q;

  assign rd_count = rd_count_q;
  assign cmd_err  = cmd_err_q;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_count_q <= 16'd0;
      cmd_err_q  <= 1'b0;
    end else begin
      if (first_load && (rd_count_q != 16'hFFFF)) rd_count_q <= rd_count_q + 16'd1;
      if ((state_d == StIgnore) && (state_q != StIgnore)) cmd_err_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: quad reads, XIP follow-ups, bad command, wrap, aborts.
module tb_qspi_flash_responder;
  localparam int unsigned MEM_AW = 12;
  localparam int unsigned DUMMY  = 4;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [7:0]        mem_wdata;
`ifdef QSPI_RESP_STATS_EN
  logic [15:0]       rd_count;
  logic              cmd_err;
`endif

  int total  = 0;
  int bad    = 0;
  int exp_rd = 0;

  qspi_flash_responder_if qif ();

  qspi_flash_responder #(
    .MEM_AW (MEM_AW),
    .DUMMY  (DUMMY)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .qspi      (qif),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata)
`ifdef QSPI_RESP_STATS_EN
    ,
    .rd_count  (rd_count),
    .cmd_err   (cmd_err)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // One sck period: low edge then high edge (the shift event).
  task automatic shift(input logic [3:0] nib);
    qif.sck = 1'b0;
    qif.din = nib;
    step();
    qif.sck = 1'b1;
    step();
  endtask

  task automatic ce_high();
    qif.ce_n = 1'b1;
    qif.sck  = 1'b0;
    qif.din  = 4'h0;
    step();
    step();
  endtask

  task automatic load(input logic [MEM_AW-1:0] a, input logic [7:0] d);
    mem_we    = 1'b1;
    mem_waddr = a;
    mem_wdata = d;
    step();
    mem_we    = 1'b0;
  endtask

  // Command (optional), address, mode and all but the last dummy slot; counts douten highs seen.
  task automatic hdr(input bit with_cmd, input logic [7:0] cmd, input logic [23:0] addr,
                     input logic [7:0] mode, output int oe_seen);
    oe_seen  = 0;
    qif.ce_n = 1'b0;
    if (with_cmd) begin
      for (int i = 7; i >= 0; i--) begin
        shift({3'b000, cmd[i]});
        if (qif.douten !== 1'b0) oe_seen++;
      end
    end
    for (int i = 5; i >= 0; i--) begin
      shift(addr[4*i +: 4]);
      if (qif.douten !== 1'b0) oe_seen++;
    end
    shift(mode[7:4]);
    if (qif.douten !== 1'b0) oe_seen++;
    shift(mode[3:0]);
    if (qif.douten !== 1'b0) oe_seen++;
    for (int i = 0; i < int'(DUMMY) - 1; i++) begin
      shift(4'h0);
      if (qif.douten !== 1'b0) oe_seen++;
    end
  endtask

  task automatic test_reset();
    HRESETn   = 1'b0;
    qif.ce_n  = 1'b1;
    qif.sck   = 1'b0;
    qif.din   = 4'h0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 8'h00;
    repeat (3) step();
    total++;
    if (qif.dout !== 4'h0) begin
      bad++;
      $display("FAIL reset_dout got=%h want=0", qif.dout);
    end
    total++;
    if (qif.douten !== 1'b0) begin
      bad++;
      $display("FAIL reset_douten got=%b want=0", qif.douten);
    end
`ifdef QSPI_RESP_STATS_EN
    total++;
    if (rd_count !== 16'd0 || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL reset_stats got=%0d/%b want=0/0", rd_count, cmd_err);
    end
`endif
    HRESETn = 1'b1;
    step();
  endtask

  task automatic test_quad_read();
    int oe;
    logic [3:0] want;
    for (int i = 0; i < 16; i++) load(MEM_AW'(12'h120 + i), 8'(i));
    hdr(1'b1, 8'hEB, 24'h000120, 8'hA5, oe);
    total++;
    if (oe !== 0) begin
      bad++;
      $display("FAIL quad_hdr_quiet douten_highs=%0d want=0", oe);
    end
    for (int k = 0; k < 32; k++) begin
      shift(4'h0);
      want = (k % 2 == 1) ? 4'(k / 2) : 4'h0;
      total++;
      if (qif.dout !== want || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL quad_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten, want);
      end
    end
    exp_rd++;
    qif.ce_n = 1'b1;
    qif.sck  = 1'b0;
    step();
    total++;
    if (qif.douten !== 1'b0) begin
      bad++;
      $display("FAIL quad_douten_fall got=%b want=0", qif.douten);
    end
    step();
  endtask

  task automatic test_xip_followup();
    int oe;
    logic [3:0] want [4] = '{4'hC, 4'h3, 4'h5, 4'hA};
    load(12'h130, 8'hC3);
    load(12'h131, 8'h5A);
    hdr(1'b0, 8'h00, 24'h000130, 8'hA5, oe);
    total++;
    if (oe !== 0) begin
      bad++;
      $display("FAIL xip_hdr_quiet douten_highs=%0d want=0", oe);
    end
    for (int k = 0; k < 4; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want[k] || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL xip_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten, want[k]);
      end
    end
    exp_rd++;
    ce_high();
  endtask

  task automatic test_xip_exit();
    int oe;
    logic [3:0] want_a [2] = '{4'hC, 4'h3};
    logic [3:0] want_b [2] = '{4'h5, 4'hA};
    hdr(1'b0, 8'h00, 24'h000130, 8'h00, oe);
    for (int k = 0; k < 2; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want_a[k]) begin
        bad++;
        $display("FAIL exit_nib k=%0d got=%h want=%h", k, qif.dout, want_a[k]);
      end
    end
    exp_rd++;
    ce_high();
    hdr(1'b1, 8'hEB, 24'h000131, 8'h00, oe);
    total++;
    if (oe !== 0) begin
      bad++;
      $display("FAIL exit_cmd_quiet douten_highs=%0d want=0", oe);
    end
    for (int k = 0; k < 2; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want_b[k] || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL exit_cmd_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten,
                 want_b[k]);
      end
    end
    exp_rd++;
    ce_high();
  endtask

  task automatic test_bad_cmd();
    int oe;
    hdr(1'b1, 8'h03, 24'h000120, 8'hA5, oe);
    for (int k = 0; k < 20; k++) begin
      shift(4'hF);
      if (qif.douten !== 1'b0) oe++;
    end
    total++;
    if (oe !== 0) begin
      bad++;
      $display("FAIL badcmd_douten douten_highs=%0d want=0", oe);
    end
    total++;
    if (qif.dout !== 4'h0) begin
      bad++;
      $display("FAIL badcmd_dout got=%h want=0", qif.dout);
    end
`ifdef QSPI_RESP_STATS_EN
    total++;
    if (cmd_err !== 1'b1 || rd_count !== 16'(exp_rd)) begin
      bad++;
      $display("FAIL badcmd_stats got=%0d/%b want=%0d/1", rd_count, cmd_err, exp_rd);
    end
`endif
    ce_high();
  endtask

  task automatic test_wrap();
    int oe;
    logic [3:0] want [4] = '{4'h9, 4'hE, 4'h4, 4'h7};
    load(12'hFFF, 8'h9E);
    load(12'h000, 8'h47);
    hdr(1'b1, 8'hEB, 24'h000FFF, 8'h00, oe);
    for (int k = 0; k < 4; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want[k] || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL wrap_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten, want[k]);
      end
    end
    exp_rd++;
    ce_high();
  endtask

  task automatic test_abort();
    int oe;
    logic [7:0] cmd = 8'hEB;
    logic [3:0] want [4] = '{4'hD, 4'h2, 4'h6, 4'hB};
    load(12'h040, 8'hD2);
    load(12'h041, 8'h6B);
    qif.ce_n = 1'b0;
    for (int i = 7; i >= 0; i--) shift({3'b000, cmd[i]});
    for (int i = 0; i < 3; i++) shift(4'h7);
    qif.ce_n = 1'b1;
    qif.sck  = 1'b0;
    step();
    total++;
    if (qif.douten !== 1'b0) begin
      bad++;
      $display("FAIL abort_douten got=%b want=0", qif.douten);
    end
    step();
    hdr(1'b1, 8'hEB, 24'h000040, 8'h00, oe);
    for (int k = 0; k < 4; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want[k] || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL abort_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten, want[k]);
      end
    end
    exp_rd++;
    ce_high();
  endtask

  task automatic test_reset_mid();
    int oe;
    logic [3:0] want [2] = '{4'h6, 4'hB};
    hdr(1'b1, 8'hEB, 24'h000040, 8'hA5, oe);
    shift(4'h0);
    shift(4'h0);
    total++;
    if (qif.dout !== 4'h2 || qif.douten !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_pre got=%h/%b want=2/1", qif.dout, qif.douten);
    end
    HRESETn = 1'b0;
    qif.sck = 1'b0;
    step();
    total++;
    if (qif.douten !== 1'b0 || qif.dout !== 4'h0) begin
      bad++;
      $display("FAIL rstmid_out got=%h/%b want=0/0", qif.dout, qif.douten);
    end
    HRESETn = 1'b1;
    exp_rd  = 0;
    ce_high();
    hdr(1'b1, 8'hEB, 24'h000041, 8'h00, oe);
    for (int k = 0; k < 2; k++) begin
      shift(4'h0);
      total++;
      if (qif.dout !== want[k] || qif.douten !== 1'b1) begin
        bad++;
        $display("FAIL rstmid_nib k=%0d got=%h/%b want=%h/1", k, qif.dout, qif.douten, want[k]);
      end
    end
    exp_rd++;
`ifdef QSPI_RESP_STATS_EN
    total++;
    if (rd_count !== 16'(exp_rd) || cmd_err !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_stats got=%0d/%b want=%0d/0", rd_count, cmd_err, exp_rd);
    end
`endif
    ce_high();
  endtask

  initial begin
    test_reset();
    test_quad_read();
    test_xip_followup();
    test_xip_exit();
    test_bad_cmd();
    test_wrap();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_flash_responder.md
Name: qspi_flash_responder

Overview:
Synthesizable Quad I/O flash responder: the flash end of the team's QSPI XIP read path. It serves QUAD I/O FAST READ (0xEB) with continuous-read (XIP) mode from an internal byte memory. It is used as an FPGA/emulation stand-in for external flash and as a bench target for the XIP controller. The controller generates sck from the same HCLK, so this block samples sck/ce_n directly on HCLK with no synchronizers.

Parameters:
MEM_AW, 12, byte-address width of internal memory (2^MEM_AW bytes); flash address taken modulo 2^MEM_AW
DUMMY, 4, dummy nibble slots after mode byte; data starts at phase count 16+DUMMY

Ports:
HCLK  in  1  clock; all logic on rising edge
HRESETn  in  1  reset, synchronous, active-low
sck  in  1  flash clock from controller (toggles per HCLK while ce_n low)
ce_n  in  1  chip enable from controller, active-low
din  in  4  IO[3:0] driven by controller (cmd on din[0], addr/mode on din[3:0])
dout  out  4  IO[3:0] read data to controller
douten  out  1  1 = responder drives dout
mem_we  in  1  load-port byte write strobe
mem_waddr  in  MEM_AW  load-port byte address
mem_wdata  in  8  load-port byte data

Behaviour:
- Single clock, HRESETn synchronous active-low: sampled only at HCLK rising edge.
- Reset values: dout=0, douten=0, pc=0, state=IDLE, xip=0; memory contents not reset.
- Shift event (SE): an HCLK edge with ce_n==0 && sck==1. Phase counter pc increments on each SE (mirrors controller counter).
- On ce_n==1 at an edge: state=IDLE, douten=0, pc=8 if xip else 0. This is an abort at any point; xip is unchanged unless the mode phase completed.
- States: IDLE -> CMD (ce_n low, xip=0) or ADDR (ce_n low, xip=1); CMD -> ADDR after 8 SEs if the command is 0xEB, else -> IGNORE; ADDR -> MODE -> DUMMY -> DATA; IGNORE/DATA persist until ce_n high.
- CMD: pc 0..7, shift din[0] MSB first into cmd reg. A command other than 8'hEB -> IGNORE: douten stays 0, dout=0.
- ADDR: pc 8..13, shift din[3:0] MSB nibble first into 24-bit addr.
- MODE: pc 14..15. At the pc==14 SE, xip <= (din==4'hA). The nibble at pc 15 is ignored.
- DUMMY: pc 16..15+DUMMY; no drive.
- DATA: at the SE with pc==15+DUMMY+k (k>=0), load dout with nibble k and set douten=1. Nibble k is the high nibble (k even) or low nibble (k odd) of mem[(addr + k/2) mod 2^MEM_AW]. dout is held stable until the next SE, so it is valid when the controller samples at pc==16+DUMMY+k.
- Reads are unbounded: the byte address increments every 2 nibbles while ce_n stays low and wraps 2^MEM_AW-1 -> 0. The controller's 16-byte lines are therefore nibbles k=0..31.
- douten falls on the first edge with ce_n==1.
- Load port: mem_we writes mem[mem_waddr] at the HCLK edge, in any state. A nibble load in the same cycle as a write to that byte returns the old byte.
- HRESETn low mid-transaction: immediate return to reset values, including xip=0; the next transaction must carry a command.

Optional Feature:
QSPI_RESP_STATS_EN: when defined, adds output rd_count [15:0] (reset 0). It increments once per transaction at the first DATA nibble load and saturates at 16'hFFFF. It also adds output cmd_err [0:0], a sticky flag set on any non-EB command and cleared only by reset. When undefined, both ports and their logic are absent.

Test Plan:
- Load mem[0x120..0x12F]=0x00..0x0F; cmd EB, addr 0x000120, mode A5 -> 32 nibbles 0,0,0,1,...,0,F on dout; douten rises at pc 20 (DUMMY=4); xip=1.
- Follow-up transaction with no command (pc starts at 8), addr 0x000130, mode A5, mem[0x130]=0xC3 -> first nibbles C,3; douten 0 during pc 8..19.
- Mode nibble 0x0 on a transaction, then next ce_n low with command EB again -> decoded correctly because xip=0.
- Cmd 0x03 -> douten stays 0 for the whole transaction; with QSPI_RESP_STATS_EN, cmd_err=1 and rd_count unchanged.
- Addr 0x000FFF, MEM_AW=12, 2 bytes read -> mem[0xFFF] then mem[0x000] (wrap).
- ce_n high after pc 10, then new EB read of 0x000040 -> correct data. Also assert HRESETn low during DATA -> next edge douten=0, dout=0, xip=0.
